// File: rtl/fifo_rd_checker_if.sv
// Handshake bundle between fifo_rd_checker (master) and the read side of the dual-clock FIFO (slave).
interface fifo_rd_checker_if #(
   parameter int DATA_WIDTH = 3,
   parameter int CNT_WIDTH  = 8
);
   logic                  start;
   logic                  empty;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  rd_en;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [CNT_WIDTH-1:0]  err_cnt;
   logic [CNT_WIDTH-1:0]  word_cnt;

   modport master (
      input  start, empty, data_out,
      output rd_en, busy, done, err, err_cnt, word_cnt
   );

   modport slave (
      output start, empty, data_out,
      input  rd_en, busy, done, err, err_cnt, word_cnt
   );
endinterface

// File: rtl/fifo_rd_checker.sv
// Burst reader for the dual-clock FIFO that checks each word against an incrementing sequence.
// Optional macro FIFO_RD_RESYNC_EN: after a mismatch the expected value realigns to data_out+1.
module fifo_rd_checker #(
   parameter int DATA_WIDTH = 3,
   parameter int BURST_LEN  = 8,
   parameter int EXP_SEED   = 1,
   parameter int CNT_WIDTH  = 8
) (
   input logic               rd_clk,
   input logic               rst_n,
   fifo_rd_checker_if.master bus
);
   localparam logic [7:0]            BURST = 8'(BURST_LEN);
   localparam logic [DATA_WIDTH-1:0] SEED  = DATA_WIDTH'(EXP_SEED);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                state;
   state_t                state_nxt;
   logic                  rd_en_q;
   logic                  vld;
   logic                  accepted;
   logic                  mismatch;
   logic [7:0]            issued;
   logic [7:0]            issued_nxt;
   logic [7:0]            checked;
   logic [7:0]            checked_nxt;
   logic [DATA_WIDTH-1:0] exp_val;
   logic [CNT_WIDTH-1:0]  err_cnt_q;
   logic [CNT_WIDTH-1:0]  word_cnt_q;

   // A read only counts when the FIFO was non-empty; a raced rd_en against a rising empty is dropped.
   always_comb begin
      accepted    = rd_en_q && !bus.empty;
      issued_nxt  = issued + 8'(accepted);
      checked_nxt = checked + 8'(vld);
      mismatch    = vld && (bus.data_out != exp_val);
   end

   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = READ;
         READ:    if (issued_nxt == BURST) state_nxt = DRAIN;
         DRAIN:   if (checked_nxt == BURST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_en_q    <= 1'b0;
         vld        <= 1'b0;
         issued     <= '0;
         checked    <= '0;
         exp_val    <= SEED;
         err_cnt_q  <= '0;
         word_cnt_q <= '0;
      end else begin
         rd_en_q <= (state == READ) && !bus.empty && (issued_nxt < BURST);
         vld     <= accepted;
         if ((state == IDLE) && bus.start) begin
            issued  <= '0;
            checked <= '0;
         end else begin
            issued  <= issued_nxt;
            checked <= checked_nxt;
         end
         if (vld) begin
            word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
            if (mismatch && (err_cnt_q != '1)) begin
               err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
            end
`ifdef FIFO_RD_RESYNC_EN
            exp_val <= mismatch ? (bus.data_out + DATA_WIDTH'(1)) : (exp_val + DATA_WIDTH'(1));
`else
            exp_val <= exp_val + DATA_WIDTH'(1);
`endif
         end
      end
   end

   always_comb begin
      bus.rd_en    = rd_en_q;
      bus.busy     = (state != IDLE);
      bus.done     = (state == DONE);
      bus.err      = mismatch;
      bus.err_cnt  = err_cnt_q;
      bus.word_cnt = word_cnt_q;
   end
endmodule

// File: doc/fifo_rd_checker.md
Name: fifo_rd_checker

Overview:
- Read-side consumer for the dual-clock FIFO. It runs in the read clock domain and drains bursts of words whenever the FIFO reports non-empty.
- It checks every word against an expected modulo-2^DATA_WIDTH incrementing sequence, matching the writer's data_in = data_in + 1 stimulus pattern.
- It is used as a synthesizable self-checking reader in FIFO bring-up benches and on-chip loopback tests.

Parameters:
- DATA_WIDTH, 3, width of FIFO data word.
- BURST_LEN, 8, words read per burst, 1..255.
- EXP_SEED, 1, expected value of the first word after reset.
- CNT_WIDTH, 8, width of word_cnt and err_cnt.

Ports:
- rd_clk  in  1  read-domain clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins one burst; ignored unless state is IDLE.
- empty  in  1  FIFO empty flag, synchronous to rd_clk.
- data_out  in  DATA_WIDTH  FIFO read data, valid one rd_clk cycle after an accepted read.
- rd_en  out  1  FIFO read request; registered.
- busy  out  1  high while state is not IDLE.
- done  out  1  one-cycle pulse when a burst completes.
- err  out  1  one-cycle pulse in the cycle a mismatched word is checked.
- err_cnt  out  CNT_WIDTH  total mismatches since reset; saturates at all-ones.
- word_cnt  out  CNT_WIDTH  total words checked since reset; wraps.

Behaviour:
- Reset (async assert, release on rd_clk): state=IDLE; rd_en=0, busy=0, done=0, err=0, err_cnt=0, word_cnt=0; exp=EXP_SEED; issue counter=0; check counter=0.
- Accepted read: a cycle with rd_en=1 and empty=0. A cycle with rd_en=1 and empty=1 is not a read and is not counted.
- Data latency: data_out for an accepted read at edge N is sampled and compared at edge N+1. A one-cycle pipeline flag (vld) tracks pending reads.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: on start, go to READ and clear the issue and check counters.
  - READ: rd_en is driven from the registered condition !empty && issued < BURST_LEN, recomputed every cycle. Issue counter increments on each accepted read. When the final accepted read occurs (issued becomes BURST_LEN), rd_en drops next edge and the FSM goes to DRAIN.
  - DRAIN: wait until the check counter reaches BURST_LEN (at most 1 cycle), then go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. exp persists across bursts.
- Empty asserted mid-burst: the FSM stays in READ with rd_en low and resumes when empty deasserts. There is no timeout.
- Registered rd_en racing with empty: because rd_en is registered it may be high in the same cycle empty rises. The read is not accepted, which is legal for the FIFO; issue and expected counters must not advance.
- Check arithmetic:
  - On each vld cycle: word_cnt+1 (wraps); exp <= exp+1 modulo 2^DATA_WIDTH. With the default DATA_WIDTH=3, 7 wraps to 0.
  - If data_out != exp: err=1 that cycle and err_cnt+1, holding at max.
- Simultaneous start and done: start is ignored outside IDLE. The DONE state blocks a start pulse in that cycle.
- Reset mid-burst: everything returns to reset values immediately; a pending vld is discarded.

Optional Feature:
- Macro: FIFO_RD_RESYNC_EN.
- Defined: on a mismatch, exp reloads to data_out+1 instead of exp+1. One dropped or duplicated word therefore produces exactly one err pulse and checking realigns.
- Undefined: exp always advances by 1, so a single slip produces an error on every subsequent word until reset.
- Port list and all other behaviour are identical in both builds.

Test Plan:
1. Preload the FIFO with 1..7,0 (DATA_WIDTH=3), pulse start -> 8 accepted reads, rd_en deasserts after the 8th, done pulses once, word_cnt=8, err_cnt=0, err never high.
2. FIFO holds 3 words when start pulses; write 5 more after 20 rd_clk cycles -> rd_en low while empty, burst resumes, done after the 8th word, no errors.
3. Inject sequence 1,2,4,5,6,7,0,1 -> without FIFO_RD_RESYNC_EN err_cnt=6; with the macro err_cnt=1, and exp=2 after the final check.
4. Deassert rst_n for 1 cycle after the 4th accepted read -> all outputs return to 0, state=IDLE, exp=EXP_SEED, no done pulse; a new start reads from 1.
5. Pulse start while busy, and again in the DONE cycle -> ignored; exactly one done per burst; a second start in IDLE runs the next burst with exp continuing at 1.
6. Hold empty=1 with rd_en high for 1 cycle (race) -> issue and check counters unchanged, no vld, no err.
